// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a byte stream before the
// pipeline runs. Bytes arrive MSB-first over valid/ready, are packed into
// 32-bit words and written to consecutive word addresses. The load ends on
// HALT_WORD (done) or when the memory is full without one (error).
module imem_loader #(
    parameter int          MEM_DEPTH_WORDS = 64,
    parameter logic [31:0] HALT_WORD       = 32'hFFFF_FFFF,
    parameter int          CW              = $clog2(MEM_DEPTH_WORDS) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load_start,
    input  logic          i_abort,
    input  logic [7:0]    i_byte,
    input  logic          i_byte_valid,
    output logic          o_byte_ready,
    output logic          o_write_en,
    output logic [31:0]   o_addr_wr,
    output logic [31:0]   o_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    output logic [CW-1:0] o_word_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt;
    logic [23:0]   asm_q;      // first three bytes of the word in flight
    logic          byte_acc;
    logic          last_byte;
    logic [CW-1:0] wc_inc;
    logic          start_ok;

    // ready/busy are pure decodes of the state register
    assign o_byte_ready = (state_q == RECV);
    assign o_busy       = (state_q == RECV) || (state_q == WRITE);

    assign byte_acc  = o_byte_ready && i_byte_valid;
    assign last_byte = byte_acc && (byte_cnt == 2'd3);
    assign wc_inc    = o_word_count + CW'(1);
    assign start_ok  = i_load_start &&
                       ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; abort overrides everything but reset
    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: if (i_load_start) state_d = RECV;
                RECV:              if (last_byte) state_d = WRITE;
                WRITE: begin
                    if (o_data == HALT_WORD)                  state_d = DONE;
                    else if (wc_inc == CW'(MEM_DEPTH_WORDS))  state_d = ERROR;
                    else                                      state_d = RECV;
                end
                default:           state_d = IDLE;
            endcase
        end
    end

    // Datapath: byte assembly, write port, counters and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt     <= '0;
            asm_q        <= '0;
            o_write_en   <= 1'b0;
            o_addr_wr    <= '0;
            o_data       <= '0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_word_count <= '0;
        end else begin
            // strobe is high for exactly the cycle spent in WRITE
            o_write_en <= (state_d == WRITE);
            if (i_abort) begin
                // drop any partial word; written words and count are kept
                byte_cnt <= '0;
                asm_q    <= '0;
                o_done   <= 1'b0;
                o_error  <= 1'b0;
            end else if (start_ok) begin
                byte_cnt     <= '0;
                o_addr_wr    <= '0;
                o_word_count <= '0;
                o_done       <= 1'b0;
                o_error      <= 1'b0;
            end else if (byte_acc) begin
                asm_q    <= {asm_q[15:0], i_byte};
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte) o_data <= {asm_q, i_byte};
            end else if (state_q == WRITE) begin
                o_addr_wr    <= o_addr_wr + 32'd4;
                o_word_count <= wc_inc;
                if (o_data == HALT_WORD)                 o_done  <= 1'b1;
                else if (wc_inc == CW'(MEM_DEPTH_WORDS)) o_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 64-word instance for the main scenarios
// and a 4-word instance for the overflow case, both driven by the same inputs.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_load_start, i_abort, i_byte_valid;
    logic [7:0]  i_byte;

    logic        rdy, we, busy, done, err;
    logic [31:0] addr, data;
    logic [6:0]  wc;

    logic        rdy4, we4, busy4, done4, err4;
    logic [31:0] addr4, data4;
    logic [2:0]  wc4;

    int total = 0;
    int bad   = 0;

    logic [31:0] wa[$], wd[$], wa4[$], wd4[$];
    int          rdy_viol = 0;

    always #5 clk = ~clk;

    imem_loader #(.MEM_DEPTH_WORDS(64)) dut (
        .clk(clk), .reset(reset), .i_load_start(i_load_start), .i_abort(i_abort),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(rdy),
        .o_write_en(we), .o_addr_wr(addr), .o_data(data), .o_busy(busy),
        .o_done(done), .o_error(err), .o_word_count(wc));

    imem_loader #(.MEM_DEPTH_WORDS(4)) dut4 (
        .clk(clk), .reset(reset), .i_load_start(i_load_start), .i_abort(i_abort),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(rdy4),
        .o_write_en(we4), .o_addr_wr(addr4), .o_data(data4), .o_busy(busy4),
        .o_done(done4), .o_error(err4), .o_word_count(wc4));

    // Memory-side observer: logs every strobe mid-cycle
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa.push_back(addr); wd.push_back(data);
            if (rdy !== 1'b0) rdy_viol++;
        end
        if (we4 === 1'b1) begin
            wa4.push_back(addr4); wd4.push_back(data4);
        end
    end

    task automatic clear_logs();
        wa.delete(); wd.delete(); wa4.delete(); wd4.delete(); rdy_viol = 0;
    endtask

    task automatic start_pulse();
        @(negedge clk); i_load_start = 1'b1;
        @(negedge clk); i_load_start = 1'b0;
    endtask

    task automatic abort_pulse();
        @(negedge clk); i_abort = 1'b1;
        @(negedge clk); i_abort = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    // Leaves valid high so the caller can stream back-to-back.
    task automatic send_byte(input logic [7:0] b, input bit sel4);
        int n = 0;
        i_byte = b; i_byte_valid = 1'b1;
        while (!(sel4 ? rdy4 : rdy) && n < 20) begin
            @(negedge clk); n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL send_byte_timeout byte=%h", b);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit sel4);
        send_byte(w[31:24], sel4); send_byte(w[23:16], sel4);
        send_byte(w[15:8],  sel4); send_byte(w[7:0],   sel4);
        i_byte_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            i_load_start = 1'($urandom); i_abort = 1'($urandom);
            i_byte = 8'($urandom); i_byte_valid = 1'($urandom);
        end
        @(negedge clk);
        total++; if ({rdy, we, busy, done, err} !== 5'b0) begin bad++;
            $display("FAIL reset_flags got=%b want=00000", {rdy, we, busy, done, err}); end
        total++; if (addr !== 32'd0 || data !== 32'd0) begin bad++;
            $display("FAIL reset_addr_data got=%h/%h want=0/0", addr, data); end
        total++; if (wc !== 7'd0) begin bad++;
            $display("FAIL reset_wc got=%0d want=0", wc); end
        reset = 1'b0; i_load_start = 0; i_abort = 0; i_byte_valid = 0; i_byte = 0;
        @(negedge clk);
        clear_logs();
    endtask

    task automatic test_normal_load();
        clear_logs();
        start_pulse();
        send_word(32'h2008_0005, 0);
        send_word(32'h2009_000A, 0);
        send_word(32'hFFFF_FFFF, 0);
        idle_cycles(3);
        total++; if (wa.size() !== 3) begin bad++;
            $display("FAIL normal_nwrites got=%0d want=3", wa.size()); end
        if (wa.size() == 3) begin
            total++; if (wa[0] !== 0 || wd[0] !== 32'h2008_0005) begin bad++;
                $display("FAIL normal_w0 got=%h@%h want=20080005@0", wd[0], wa[0]); end
            total++; if (wa[1] !== 4 || wd[1] !== 32'h2009_000A) begin bad++;
                $display("FAIL normal_w1 got=%h@%h want=2009000a@4", wd[1], wa[1]); end
            total++; if (wa[2] !== 8 || wd[2] !== 32'hFFFF_FFFF) begin bad++;
                $display("FAIL normal_w2 got=%h@%h want=ffffffff@8", wd[2], wa[2]); end
        end
        total++; if ({done, err, busy, rdy} !== 4'b1000) begin bad++;
            $display("FAIL normal_status got=%b want=1000", {done, err, busy, rdy}); end
        total++; if (wc !== 7'd3) begin bad++;
            $display("FAIL normal_wc got=%0d want=3", wc); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        clear_logs();
        start_pulse();
        total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL b2b_restart got done=%b busy=%b want 0/1", done, busy); end
        for (int i = 0; i < 8; i++) begin
            b = 8'h11 + 8'(i);
            send_byte(b, 0);
        end
        send_word(32'hFFFF_FFFF, 0);
        idle_cycles(3);
        total++; if (wa.size() !== 3) begin bad++;
            $display("FAIL b2b_nwrites got=%0d want=3", wa.size()); end
        if (wa.size() == 3) begin
            total++; if (wa[0] !== 0 || wd[0] !== 32'h1112_1314) begin bad++;
                $display("FAIL b2b_w0 got=%h@%h want=11121314@0", wd[0], wa[0]); end
            total++; if (wa[1] !== 4 || wd[1] !== 32'h1516_1718) begin bad++;
                $display("FAIL b2b_w1 got=%h@%h want=15161718@4", wd[1], wa[1]); end
        end
        total++; if (rdy_viol !== 0) begin bad++;
            $display("FAIL b2b_ready_in_write got=%0d want=0", rdy_viol); end
    endtask

    task automatic test_overflow();
        clear_logs();
        start_pulse();
        for (int k = 0; k < 4; k++) send_word(32'h0102_0304 + 32'(k), 1);
        // fifth word: offered but must never be taken
        i_byte = 8'h55; i_byte_valid = 1'b1;
        idle_cycles(10);
        i_byte_valid = 1'b0;
        total++; if (wa4.size() !== 4) begin bad++;
            $display("FAIL ovf_nwrites got=%0d want=4", wa4.size()); end
        for (int k = 0; k < 4 && k < wa4.size(); k++) begin
            total++; if (wa4[k] !== 32'(4*k) || wd4[k] !== 32'h0102_0304 + 32'(k)) begin bad++;
                $display("FAIL ovf_w%0d got=%h@%h want=%h@%h", k, wd4[k], wa4[k],
                         32'h0102_0304 + 32'(k), 32'(4*k)); end
        end
        total++; if ({err4, done4, busy4, rdy4} !== 4'b1000) begin bad++;
            $display("FAIL ovf_status got=%b want=1000", {err4, done4, busy4, rdy4}); end
        total++; if (wc4 !== 3'd4) begin bad++;
            $display("FAIL ovf_wc got=%0d want=4", wc4); end
        abort_pulse();
        total++; if (err4 !== 1'b0) begin bad++;
            $display("FAIL ovf_abort_clears got=%b want=0", err4); end
    endtask

    task automatic test_abort();
        int n;
        clear_logs();
        start_pulse();
        send_word(32'hAABB_CCDD, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        i_byte_valid = 1'b0;
        abort_pulse();
        idle_cycles(2);
        total++; if (wa.size() !== 1) begin bad++;
            $display("FAIL abort_nwrites got=%0d want=1", wa.size()); end
        total++; if ({busy, rdy, done} !== 3'b000 || wc !== 7'd1) begin bad++;
            $display("FAIL abort_state got busy/rdy/done=%b wc=%0d want 000 wc=1",
                     {busy, rdy, done}, wc); end
        clear_logs();
        start_pulse();
        send_word(32'hFFFF_FFFF, 0);
        idle_cycles(2);
        n = wa.size();
        total++; if (n !== 1 || wa[0] !== 0 || wd[0] !== 32'hFFFF_FFFF) begin bad++;
            $display("FAIL abort_reload got n=%0d want 1 write ffffffff@0", n); end
        total++; if (done !== 1'b1 || wc !== 7'd1) begin bad++;
            $display("FAIL abort_reload_status got done=%b wc=%0d want 1/1", done, wc); end
    endtask

    task automatic test_reset_mid_load();
        clear_logs();
        start_pulse();
        send_word(32'h0000_0001, 0);
        send_word(32'h0000_0002, 0);
        send_byte(8'hA1, 0); send_byte(8'hA2, 0); send_byte(8'hA3, 0);
        i_byte_valid = 1'b0;
        clear_logs();
        reset = 1'b1;
        @(negedge clk);
        total++; if ({rdy, we, busy, done, err} !== 5'b0 || addr !== 0 || data !== 0 || wc !== 0) begin
            bad++;
            $display("FAIL midreset_outputs got flags=%b addr=%h data=%h wc=%0d want all 0",
                     {rdy, we, busy, done, err}, addr, data, wc); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (wa.size() !== 0) begin bad++;
            $display("FAIL midreset_strobe got=%0d want=0", wa.size()); end
        start_pulse();
        send_word(32'hCAFE_0001, 0);
        send_word(32'hFFFF_FFFF, 0);
        idle_cycles(2);
        total++; if (wa.size() !== 2 || wa[0] !== 0 || wd[0] !== 32'hCAFE_0001) begin bad++;
            $display("FAIL midreset_reload got n=%0d want cafe0001@0 first", wa.size()); end
    endtask

    initial begin
        reset = 1'b1; i_load_start = 0; i_abort = 0; i_byte = 0; i_byte_valid = 0;
        test_reset();
        test_normal_load();
        test_back_to_back();
        test_overflow();
        test_abort();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequencer that fills the instruction memory from a byte stream before the MIPS pipeline runs. It accepts bytes over a valid/ready handshake and assembles them big-endian into 32-bit words. Each word is written to consecutive word addresses of the instruction memory through its write port (`write_en`, `addr_wr`, `data`). It signals the pipeline to stay held while loading and reports completion on a halt word, or an error when memory overflows.

## Interface
- `MEM_DEPTH_WORDS`, 64: instruction memory capacity in 32-bit words; must be ≥ 2.
- `HALT_WORD`, 32'hFFFF_FFFF: terminator word; it is written to memory and then ends the load.
- `CW`, $clog2(MEM_DEPTH_WORDS)+1: width of the word counter.

- `clk` in 1: single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `i_load_start` in 1: one-cycle pulse that begins a load. Accepted only in IDLE, DONE or ERROR.
- `i_abort` in 1: returns the block to IDLE from any state.
- `i_byte` in 8: incoming byte; the first byte of each word is the MSB.
- `i_byte_valid` in 1: `i_byte` is valid. The source holds `i_byte` until the byte is accepted.
- `o_byte_ready` out 1: the block can accept a byte this cycle.
- `o_write_en` out 1: write strobe to the instruction memory.
- `o_addr_wr` out 32: byte address for the write, always a multiple of 4.
- `o_data` out 32: word to write.
- `o_busy` out 1: high while loading; the pipeline is held while this is high.
- `o_done` out 1: load ended on `HALT_WORD`.
- `o_error` out 1: memory filled without seeing `HALT_WORD`.
- `o_word_count` out CW: number of words written in the current or last load.

## Operation
- **States:** IDLE, RECV, WRITE, DONE, ERROR.
- **Reset:** state goes to IDLE. Every output is 0, including `o_addr_wr`, `o_data` and `o_word_count`. The byte counter and assembly register are cleared.
- **IDLE:** `o_byte_ready` is 0. On `i_load_start`, go to RECV and clear the byte counter, address and `o_word_count`.
- **DONE / ERROR:** the matching flag (`o_done` or `o_error`) stays high. `i_load_start` clears the flag and behaves as it does in IDLE.
- **RECV:**
  - `o_byte_ready` = 1 and `o_busy` = 1.
  - A byte is accepted on any edge where `i_byte_valid` & `o_byte_ready`: `asm <= {asm[23:0], i_byte}` and `byte_cnt <= byte_cnt + 1`, a 2-bit counter that wraps.
  - Accepting the 4th byte moves the state to WRITE and loads `o_data` with the completed word.
- **WRITE:** lasts exactly one cycle.
  - `o_write_en` = 1 and `o_byte_ready` = 0.
  - At the end of the cycle: `o_addr_wr += 4` and `o_word_count += 1`.
  - Next state:
    - if `o_data == HALT_WORD`, go to DONE;
    - otherwise, if the new word count equals `MEM_DEPTH_WORDS`, go to ERROR;
    - otherwise, return to RECV.
- **Abort:** `i_abort` in any state goes to IDLE on the next edge.
  - A partially assembled word is discarded and no write is issued.
  - Words already written stay in memory, and `o_word_count` holds its value.
  - Flags clear.
- **Priority:** `reset` > `i_abort` > `i_load_start`. `i_load_start` during RECV or WRITE is ignored.
- **Output signals:** `o_busy` = (state is RECV or WRITE). `o_write_en` is never high outside WRITE, and there is never more than one strobe per word.
- **Address range:** `o_addr_wr` never exceeds 4·(MEM_DEPTH_WORDS−1) while `o_write_en` is high.

## Timing
- If the 4th byte of a word is accepted at edge N, `o_write_en` is high during cycle N→N+1 and memory captures the word at edge N+1.
- `o_byte_ready` is low for that one cycle and returns high after edge N+1.
- **Throughput:** at most 1 word per 5 cycles.
- **Address sequence:** 0, 4, 8, …. The k-th word (counting from 0) is written at 4k.
- `o_done` or `o_error` rises at the edge ending the final WRITE, and `o_busy` falls at that same edge.
- Outputs are registered except `o_byte_ready` and `o_busy`, which decode the state register directly (no path from inputs).
- A byte held valid across the WRITE cycle is accepted on the first RECV cycle after it. No byte is lost or duplicated.

## Test plan
- **Reset:** hold `reset` for 2 cycles with random inputs → all outputs 0, no `o_write_en`.
- **Normal load:** pulse start, then stream bytes 20 08 00 05, 20 09 00 0A, FF FF FF FF → exactly three one-cycle writes: addr 0 = 0x20080005, addr 4 = 0x2009000A, addr 8 = 0xFFFFFFFF. Then `o_done` = 1, `o_word_count` = 3, `o_busy` = 0.
- **Overflow (MEM_DEPTH_WORDS = 4):** send 5 non-halt words → writes at 0, 4, 8, 12 only. Then `o_error` = 1, `o_word_count` = 4, no 5th strobe, `o_byte_ready` = 0.
- **Back-pressure:** hold `i_byte_valid` high continuously for 8 bytes 11..18 → words 0x11121314 @0 and 0x15161718 @4. `o_byte_ready` is low in each WRITE cycle.
- **Abort:** 2 bytes into word 1, pulse `i_abort` → no write for word 1, state IDLE, `o_word_count` = 1. A following start-plus-halt load writes 0xFFFFFFFF @0.
- **Reset mid-load:** assert `reset` with 3 bytes of word 2 accepted → next edge all outputs 0, no strobe. A subsequent load restarts at addr 0.
